lc3_io_ctrl: RTL and testbench
==============================

Name: lc3_io_ctrl

Overview:
Address-control and memory-mapped I/O stage that sits alongside the LC-3 memory block on main_bus. It shadows MAR/MDR loads and decodes the device-register page. It steers MIO_EN to memory for normal addresses and services KBSR/KBDR/DSR/DDR/MCR accesses itself, with the same one-cycle R timing as memory. It provides valid/ready handshakes to keyboard and display devices and level interrupt requests.

Parameters:
KBSR_ADDR, 16'hFE00, keyboard status register address
KBDR_ADDR, 16'hFE02, keyboard data register address
DSR_ADDR, 16'hFE04, display status register address
DDR_ADDR, 16'hFE06, display data register address
MCR_ADDR, 16'hFFFE, machine control register address

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
main_bus  in  16  snooped bus value (never driven here)
LD_MAR  in  1  MAR load strobe from control
LD_MDR  in  1  MDR load strobe from control
MIO_EN  in  1  memory/IO access enable from control
RW  in  1  1=write, 0=read
mem_en  out  1  gated MIO_EN to memory block
io_sel  out  1  1=current address is a device register (selects io_rdata into MDR path)
io_rdata  out  16  registered device-register read data
R  out  1  ready for I/O accesses
kb_data  in  8  keyboard character
kb_valid  in  1  keyboard character valid
kb_ready  out  1  keyboard may transfer
disp_data  out  8  display character
disp_valid  out  1  display character valid
disp_ready  in  1  display accepts character
kbd_irq  out  1  keyboard interrupt request
disp_irq  out  1  display interrupt request
mcr_run  out  1  MCR[15], clock-enable to rest of machine

Behaviour:
- One clock, clk; reset asynchronous, active-low (rst_n). All state resets immediately on rst_n=0, including mid-access.
- Reset values: shadow MAR=0, shadow MDR=0, KBSR=0, KBDR=0, DSR=16'h8000, DDR=0, MCR=16'h8000, io_rdata=0, R=0, disp_valid=0. Derived: kb_ready=1, mcr_run=1, irqs=0.
- Shadow MAR <= main_bus on posedge when LD_MAR. Shadow MDR <= main_bus on posedge when LD_MDR && !MIO_EN.
- io_hit = shadow MAR equals any of the five addresses. Combinational: io_sel=io_hit; mem_en=MIO_EN && !io_hit.
- R registered: R <= MIO_EN && io_hit each edge. Memory produces its own R; the integrator ORs the two.
- Read (MIO_EN, !RW, io_hit): io_rdata <= register value at this edge, using pre-edge state:
  - KBSR: {KBSR[15], KBSR[14], 14'b0}
  - KBDR: {8'h00, KBDR}
  - DSR: {DSR[15], DSR[14], 14'b0}
  - DDR: {8'h00, DDR}
  - MCR: MCR
- A KBDR read clears KBSR[15] at the same edge. Repeated cycles are harmless.
- Write (MIO_EN, RW, io_hit), data = shadow MDR:
  - KBSR: only bit14 (IE) written.
  - DSR: only bit14 written.
  - KBDR: ignored.
  - MCR: all 16 bits written.
  - DDR: accepted only if DSR[15]=1. Then DDR<=MDR[7:0], DSR[15]<=0, disp_valid<=1. If DSR[15]=0, the write is dropped, so a held write strobe cannot issue twice.
- Keyboard: kb_ready = !KBSR[15]. On an edge with kb_valid && kb_ready: KBDR<=kb_data, KBSR[15]<=1. No transfer/read conflict is possible, since a KBDR read requires KBSR[15]=1, which forces kb_ready=0.
- Display: disp_data=DDR. disp_valid is held until an edge with disp_valid && disp_ready; then disp_valid<=0 and DSR[15]<=1. If a DDR write and a completing handshake share an edge, the handshake completes and the write is dropped (DSR[15] was 0 pre-edge).
- kbd_irq = KBSR[15]&&KBSR[14]; disp_irq = DSR[15]&&DSR[14]; mcr_run = MCR[15].
- Non-I/O addresses: io_rdata holds its last value, R stays 0, and device state is unchanged.

Test Plan:
- Reset then LD_MAR with bus=16'h3000, MIO_EN=1, RW=0 -> mem_en=1, io_sel=0, R stays 0; mcr_run=1, kb_ready=1.
- kb_data=8'h41, kb_valid=1 for one cycle -> KBSR[15]=1, kb_ready=0. Read FE00 -> io_rdata=16'h8000, R=1 the next cycle. Read FE02 -> io_rdata=16'h0041, KBSR[15]=0, kb_ready=1. Throughout: mem_en=0.
- MDR=16'h005A, write FE06 with disp_ready=0 -> disp_valid=1, disp_data=8'h5A, DSR read=16'h0000. A second write of 16'h0042 is dropped. disp_ready=1 for one cycle -> disp_valid=0, DSR read=16'h8000.
- Write FE00 with MDR=16'hFFFF -> KBSR=16'h4000, kbd_irq=0. A keypress then gives kbd_irq=1, and the KBDR read drops it.
- Write FFFE with MDR=16'h0000 -> mcr_run=0. Read FFFE -> io_rdata=16'h0000.
- Assert rst_n=0 mid-display-transfer (disp_valid=1) -> disp_valid=0, DSR=16'h8000, R=0 asynchronously, without waiting for clk.

Source files
------------

// File: rtl/lc3_io_ctrl_if.sv
// Bus and device-handshake signals of the LC-3 address-control / memory-mapped I/O stage.
// master = control unit and devices; slave = lc3_io_ctrl.
interface lc3_io_ctrl_if;
    logic [15:0] main_bus;
    logic        LD_MAR;
    logic        LD_MDR;
    logic        MIO_EN;
    logic        RW;
    logic        mem_en;
    logic        io_sel;
    logic [15:0] io_rdata;
    logic        R;
    logic [7:0]  kb_data;
    logic        kb_valid;
    logic        kb_ready;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic        disp_ready;
    logic        kbd_irq;
    logic        disp_irq;
    logic        mcr_run;

    modport master (
        output main_bus, LD_MAR, LD_MDR, MIO_EN, RW, kb_data, kb_valid, disp_ready,
        input  mem_en, io_sel, io_rdata, R, kb_ready, disp_data, disp_valid,
               kbd_irq, disp_irq, mcr_run
    );

    modport slave (
        input  main_bus, LD_MAR, LD_MDR, MIO_EN, RW, kb_data, kb_valid, disp_ready,
        output mem_en, io_sel, io_rdata, R, kb_ready, disp_data, disp_valid,
               kbd_irq, disp_irq, mcr_run
    );
endinterface

// File: rtl/lc3_io_ctrl.sv
// LC-3 address-control and memory-mapped I/O stage: shadows MAR/MDR, decodes the
// device page, and serves KBSR/KBDR/DSR/DDR/MCR with one-cycle R timing.
module lc3_io_ctrl #(
    parameter logic [15:0] KBSR_ADDR = 16'hFE00,
    parameter logic [15:0] KBDR_ADDR = 16'hFE02,
    parameter logic [15:0] DSR_ADDR  = 16'hFE04,
    parameter logic [15:0] DDR_ADDR  = 16'hFE06,
    parameter logic [15:0] MCR_ADDR  = 16'hFFFE
) (
    input  logic         clk,
    input  logic         rst_n,
    lc3_io_ctrl_if.slave bus
);
    logic [15:0] mar_q, mar_d;
    logic [15:0] mdr_q, mdr_d;
    logic        kbsr_rdy_q, kbsr_rdy_d;
    logic        kbsr_ie_q, kbsr_ie_d;
    logic [7:0]  kbdr_q, kbdr_d;
    logic        dsr_rdy_q, dsr_rdy_d;
    logic        dsr_ie_q, dsr_ie_d;
    logic [7:0]  ddr_q, ddr_d;
    logic [15:0] mcr_q, mcr_d;
    logic [15:0] io_rdata_q, io_rdata_d;
    logic        r_q, r_d;
    logic        disp_valid_q, disp_valid_d;

    logic        io_hit_s;
    logic        rd_en_s;
    logic        wr_en_s;
    logic [15:0] rd_val_s;

    // Device-page decode and read-data selection from pre-edge state.
    always_comb begin
        io_hit_s = (mar_q == KBSR_ADDR) || (mar_q == KBDR_ADDR) || (mar_q == DSR_ADDR) ||
                   (mar_q == DDR_ADDR)  || (mar_q == MCR_ADDR);
        rd_en_s  = bus.MIO_EN && !bus.RW && io_hit_s;
        wr_en_s  = bus.MIO_EN &&  bus.RW && io_hit_s;
        case (mar_q)
            KBSR_ADDR: rd_val_s = {kbsr_rdy_q, kbsr_ie_q, 14'b0};
            KBDR_ADDR: rd_val_s = {8'h00, kbdr_q};
            DSR_ADDR:  rd_val_s = {dsr_rdy_q, dsr_ie_q, 14'b0};
            DDR_ADDR:  rd_val_s = {8'h00, ddr_q};
            MCR_ADDR:  rd_val_s = mcr_q;
            default:   rd_val_s = io_rdata_q;
        endcase
    end

    // Next-state logic for shadows, device registers and handshakes.
    always_comb begin
        mar_d        = bus.LD_MAR ? bus.main_bus : mar_q;
        mdr_d        = (bus.LD_MDR && !bus.MIO_EN) ? bus.main_bus : mdr_q;
        kbsr_rdy_d   = kbsr_rdy_q;
        kbsr_ie_d    = kbsr_ie_q;
        kbdr_d       = kbdr_q;
        dsr_rdy_d    = dsr_rdy_q;
        dsr_ie_d     = dsr_ie_q;
        ddr_d        = ddr_q;
        mcr_d        = mcr_q;
        io_rdata_d   = io_rdata_q;
        disp_valid_d = disp_valid_q;
        r_d          = bus.MIO_EN && io_hit_s;

        // A KBDR read needs KBSR[15]=1, which blocks kb_ready, so these never collide.
        if (rd_en_s) begin
            io_rdata_d = rd_val_s;
            if (mar_q == KBDR_ADDR) begin
                kbsr_rdy_d = 1'b0;
            end else begin
                kbsr_rdy_d = kbsr_rdy_q;
            end
        end else begin
            io_rdata_d = io_rdata_q;
        end

        if (bus.kb_valid && !kbsr_rdy_q) begin
            kbdr_d     = bus.kb_data;
            kbsr_rdy_d = 1'b1;
        end else begin
            kbdr_d = kbdr_q;
        end

        if (disp_valid_q && bus.disp_ready) begin
            disp_valid_d = 1'b0;
            dsr_rdy_d    = 1'b1;
        end else begin
            disp_valid_d = disp_valid_q;
        end

        if (wr_en_s) begin
            case (mar_q)
                KBSR_ADDR: kbsr_ie_d = mdr_q[14];
                DSR_ADDR:  dsr_ie_d  = mdr_q[14];
                MCR_ADDR:  mcr_d     = mdr_q;
                DDR_ADDR: begin
                    // Only accepted while the display is idle; a held strobe cannot re-issue.
                    if (dsr_rdy_q) begin
                        ddr_d        = mdr_q[7:0];
                        dsr_rdy_d    = 1'b0;
                        disp_valid_d = 1'b1;
                    end else begin
                        ddr_d = ddr_q;
                    end
                end
                default: mcr_d = mcr_q;
            endcase
        end else begin
            mcr_d = mcr_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mar_q        <= 16'h0000;
            mdr_q        <= 16'h0000;
            kbsr_rdy_q   <= 1'b0;
            kbsr_ie_q    <= 1'b0;
            kbdr_q       <= 8'h00;
            dsr_rdy_q    <= 1'b1;
            dsr_ie_q     <= 1'b0;
            ddr_q        <= 8'h00;
            mcr_q        <= 16'h8000;
            io_rdata_q   <= 16'h0000;
            r_q          <= 1'b0;
            disp_valid_q <= 1'b0;
        end else begin
            mar_q        <= mar_d;
            mdr_q        <= mdr_d;
            kbsr_rdy_q   <= kbsr_rdy_d;
            kbsr_ie_q    <= kbsr_ie_d;
            kbdr_q       <= kbdr_d;
            dsr_rdy_q    <= dsr_rdy_d;
            dsr_ie_q     <= dsr_ie_d;
            ddr_q        <= ddr_d;
            mcr_q        <= mcr_d;
            io_rdata_q   <= io_rdata_d;
            r_q          <= r_d;
            disp_valid_q <= disp_valid_d;
        end
    end

    assign bus.io_sel     = io_hit_s;
    assign bus.mem_en     = bus.MIO_EN && !io_hit_s;
    assign bus.io_rdata   = io_rdata_q;
    assign bus.R          = r_q;
    assign bus.kb_ready   = !kbsr_rdy_q;
    assign bus.disp_data  = ddr_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.kbd_irq    = kbsr_rdy_q && kbsr_ie_q;
    assign bus.disp_irq   = dsr_rdy_q && dsr_ie_q;
    assign bus.mcr_run    = mcr_q[15];
endmodule

// File: tb/tb_lc3_io_ctrl.sv
// Directed self-checking bench for lc3_io_ctrl: one task per feature, hand-computed expectations.
module tb_lc3_io_ctrl;
    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    lc3_io_ctrl_if bus_if ();

    lc3_io_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mar(input logic [15:0] a);
        bus_if.main_bus = a;
        bus_if.LD_MAR   = 1'b1;
        tick();
        bus_if.LD_MAR   = 1'b0;
    endtask

    task automatic load_mdr(input logic [15:0] d);
        bus_if.main_bus = d;
        bus_if.LD_MDR   = 1'b1;
        bus_if.MIO_EN   = 1'b0;
        tick();
        bus_if.LD_MDR   = 1'b0;
    endtask

    task automatic io_read(input logic [15:0] a);
        load_mar(a);
        bus_if.RW     = 1'b0;
        bus_if.MIO_EN = 1'b1;
        tick();
        bus_if.MIO_EN = 1'b0;
    endtask

    task automatic io_write(input logic [15:0] a, input logic [15:0] d);
        load_mdr(d);
        load_mar(a);
        bus_if.RW     = 1'b1;
        bus_if.MIO_EN = 1'b1;
        tick();
        bus_if.MIO_EN = 1'b0;
        bus_if.RW     = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++;
        if ({bus_if.mcr_run, bus_if.kb_ready, bus_if.disp_valid, bus_if.R,
             bus_if.kbd_irq, bus_if.disp_irq} !== 6'b110000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 110000",
                     {bus_if.mcr_run, bus_if.kb_ready, bus_if.disp_valid, bus_if.R,
                      bus_if.kbd_irq, bus_if.disp_irq});
        end
        tests_run++;
        if (bus_if.io_rdata !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_io_rdata: got %h expected 0000", bus_if.io_rdata);
        end
    endtask

    task automatic test_mem_addr();
        load_mar(16'h3000);
        bus_if.RW     = 1'b0;
        bus_if.MIO_EN = 1'b1;
        #1;
        tests_run++;
        if ({bus_if.mem_en, bus_if.io_sel} !== 2'b10) begin
            tests_failed++;
            $display("FAIL mem_decode: got mem_en/io_sel %b expected 10", {bus_if.mem_en, bus_if.io_sel});
        end
        tick();
        tests_run++;
        if (bus_if.R !== 1'b0 || bus_if.io_rdata !== 16'h0000) begin
            tests_failed++;
            $display("FAIL mem_no_r: got R=%b io_rdata=%h expected R=0 io_rdata=0000", bus_if.R, bus_if.io_rdata);
        end
        bus_if.MIO_EN = 1'b0;
    endtask

    task automatic test_keyboard();
        bus_if.kb_data  = 8'h41;
        bus_if.kb_valid = 1'b1;
        tick();
        bus_if.kb_valid = 1'b0;
        tests_run++;
        if (bus_if.kb_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL kb_ready_after_key: got %b expected 0", bus_if.kb_ready);
        end
        load_mar(16'hFE00);
        bus_if.RW     = 1'b0;
        bus_if.MIO_EN = 1'b1;
        #1;
        tests_run++;
        if ({bus_if.mem_en, bus_if.io_sel} !== 2'b01) begin
            tests_failed++;
            $display("FAIL io_decode: got mem_en/io_sel %b expected 01", {bus_if.mem_en, bus_if.io_sel});
        end
        tick();
        bus_if.MIO_EN = 1'b0;
        tests_run++;
        if (bus_if.io_rdata !== 16'h8000 || bus_if.R !== 1'b1) begin
            tests_failed++;
            $display("FAIL kbsr_read: got %h R=%b expected 8000 R=1", bus_if.io_rdata, bus_if.R);
        end
        io_read(16'hFE02);
        tests_run++;
        if (bus_if.io_rdata !== 16'h0041 || bus_if.kb_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL kbdr_read: got %h kb_ready=%b expected 0041 kb_ready=1", bus_if.io_rdata, bus_if.kb_ready);
        end
        tick();
        tests_run++;
        if (bus_if.R !== 1'b0) begin
            tests_failed++;
            $display("FAIL r_drop: got %b expected 0", bus_if.R);
        end
    endtask

    task automatic test_display();
        bus_if.disp_ready = 1'b0;
        io_write(16'hFE06, 16'h005A);
        tests_run++;
        if (bus_if.disp_valid !== 1'b1 || bus_if.disp_data !== 8'h5A) begin
            tests_failed++;
            $display("FAIL ddr_write: got valid=%b data=%h expected valid=1 data=5a", bus_if.disp_valid, bus_if.disp_data);
        end
        io_read(16'hFE04);
        tests_run++;
        if (bus_if.io_rdata !== 16'h0000) begin
            tests_failed++;
            $display("FAIL dsr_busy: got %h expected 0000", bus_if.io_rdata);
        end
        io_write(16'hFE06, 16'h0042);
        tests_run++;
        if (bus_if.disp_data !== 8'h5A || bus_if.disp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL ddr_drop: got data=%h valid=%b expected data=5a valid=1", bus_if.disp_data, bus_if.disp_valid);
        end
        bus_if.disp_ready = 1'b1;
        tick();
        bus_if.disp_ready = 1'b0;
        tests_run++;
        if (bus_if.disp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL disp_handshake: got valid=%b expected 0", bus_if.disp_valid);
        end
        io_read(16'hFE04);
        tests_run++;
        if (bus_if.io_rdata !== 16'h8000) begin
            tests_failed++;
            $display("FAIL dsr_ready: got %h expected 8000", bus_if.io_rdata);
        end
    endtask

    task automatic test_kbd_irq();
        io_write(16'hFE00, 16'hFFFF);
        io_read(16'hFE00);
        tests_run++;
        if (bus_if.io_rdata !== 16'h4000 || bus_if.kbd_irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL kbsr_ie: got %h irq=%b expected 4000 irq=0", bus_if.io_rdata, bus_if.kbd_irq);
        end
        bus_if.kb_data  = 8'h42;
        bus_if.kb_valid = 1'b1;
        tick();
        bus_if.kb_valid = 1'b0;
        tests_run++;
        if (bus_if.kbd_irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL kbd_irq_set: got %b expected 1", bus_if.kbd_irq);
        end
        io_read(16'hFE00);
        tests_run++;
        if (bus_if.io_rdata !== 16'hC000) begin
            tests_failed++;
            $display("FAIL kbsr_full: got %h expected c000", bus_if.io_rdata);
        end
        io_read(16'hFE02);
        tests_run++;
        if (bus_if.io_rdata !== 16'h0042 || bus_if.kbd_irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL kbd_irq_clear: got %h irq=%b expected 0042 irq=0", bus_if.io_rdata, bus_if.kbd_irq);
        end
    endtask

    task automatic test_disp_irq();
        io_write(16'hFE04, 16'h4000);
        tests_run++;
        if (bus_if.disp_irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL disp_irq_set: got %b expected 1", bus_if.disp_irq);
        end
        io_write(16'hFE04, 16'h8000);
        tests_run++;
        if (bus_if.disp_irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL disp_irq_clear: got %b expected 0", bus_if.disp_irq);
        end
    endtask

    task automatic test_mcr();
        io_write(16'hFFFE, 16'h0000);
        tests_run++;
        if (bus_if.mcr_run !== 1'b0) begin
            tests_failed++;
            $display("FAIL mcr_stop: got %b expected 0", bus_if.mcr_run);
        end
        io_read(16'hFFFE);
        tests_run++;
        if (bus_if.io_rdata !== 16'h0000) begin
            tests_failed++;
            $display("FAIL mcr_read0: got %h expected 0000", bus_if.io_rdata);
        end
        io_write(16'hFFFE, 16'h8123);
        io_read(16'hFFFE);
        tests_run++;
        if (bus_if.io_rdata !== 16'h8123 || bus_if.mcr_run !== 1'b1) begin
            tests_failed++;
            $display("FAIL mcr_read1: got %h run=%b expected 8123 run=1", bus_if.io_rdata, bus_if.mcr_run);
        end
    endtask

    task automatic test_non_io();
        io_read(16'hFE01);
        tests_run++;
        if (bus_if.io_rdata !== 16'h8123 || bus_if.R !== 1'b0) begin
            tests_failed++;
            $display("FAIL non_io_hold: got %h R=%b expected 8123 R=0", bus_if.io_rdata, bus_if.R);
        end
        io_write(16'h3000, 16'h0000);
        tests_run++;
        if (bus_if.mcr_run !== 1'b1 || bus_if.disp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL non_io_write: got run=%b valid=%b expected run=1 valid=0", bus_if.mcr_run, bus_if.disp_valid);
        end
    endtask

    task automatic test_back_to_back();
        io_write(16'hFE06, 16'h0011);
        load_mdr(16'h0022);
        load_mar(16'hFE06);
        bus_if.RW         = 1'b1;
        bus_if.MIO_EN     = 1'b1;
        bus_if.disp_ready = 1'b1;
        tick();
        bus_if.MIO_EN     = 1'b0;
        bus_if.RW         = 1'b0;
        bus_if.disp_ready = 1'b0;
        tests_run++;
        if (bus_if.disp_valid !== 1'b0 || bus_if.disp_data !== 8'h11) begin
            tests_failed++;
            $display("FAIL write_vs_handshake: got valid=%b data=%h expected valid=0 data=11", bus_if.disp_valid, bus_if.disp_data);
        end
        io_read(16'hFE04);
        tests_run++;
        if (bus_if.io_rdata !== 16'h8000) begin
            tests_failed++;
            $display("FAIL dsr_after_race: got %h expected 8000", bus_if.io_rdata);
        end
    endtask

    task automatic test_async_reset();
        io_write(16'hFFFE, 16'h0000);
        io_write(16'hFE06, 16'h0033);
        load_mar(16'hFE04);
        bus_if.RW     = 1'b0;
        bus_if.MIO_EN = 1'b1;
        tick();
        tests_run++;
        if (bus_if.disp_valid !== 1'b1 || bus_if.R !== 1'b1 || bus_if.mcr_run !== 1'b0) begin
            tests_failed++;
            $display("FAIL pre_reset: got valid=%b R=%b run=%b expected 1 1 0", bus_if.disp_valid, bus_if.R, bus_if.mcr_run);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus_if.disp_valid, bus_if.R, bus_if.mcr_run, bus_if.kb_ready} !== 4'b0011 ||
            bus_if.io_rdata !== 16'h0000) begin
            tests_failed++;
            $display("FAIL async_reset: got valid/R/run/kb_ready=%b io_rdata=%h expected 0011 0000",
                     {bus_if.disp_valid, bus_if.R, bus_if.mcr_run, bus_if.kb_ready}, bus_if.io_rdata);
        end
        bus_if.MIO_EN = 1'b0;
        tick();
        rst_n = 1'b1;
        io_read(16'hFE04);
        tests_run++;
        if (bus_if.io_rdata !== 16'h8000) begin
            tests_failed++;
            $display("FAIL dsr_after_reset: got %h expected 8000", bus_if.io_rdata);
        end
    endtask

    initial begin
        tests_run         = 0;
        tests_failed      = 0;
        rst_n             = 1'b0;
        bus_if.main_bus   = 16'h0000;
        bus_if.LD_MAR     = 1'b0;
        bus_if.LD_MDR     = 1'b0;
        bus_if.MIO_EN     = 1'b0;
        bus_if.RW         = 1'b0;
        bus_if.kb_data    = 8'h00;
        bus_if.kb_valid   = 1'b0;
        bus_if.disp_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_mem_addr();
        test_keyboard();
        test_display();
        test_kbd_irq();
        test_disp_irq();
        test_mcr();
        test_non_io();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
